// File: rtl/vending_machine_credit.sv
// Coin-operated vending controller: accumulates credit, vends at PRICE, returns excess as change pulses.
// Optional feature macro VM_CANCEL_EN: cancel in COLLECT refunds the full credit as change.
module vending_machine_credit #(
   parameter int PRICE       = 15,
   parameter int COIN_LO_VAL = 5,
   parameter int COIN_HI_VAL = 10,
   parameter int CREDIT_W    = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_lo,
   input  logic                coin_hi,
   input  logic                cancel,
   output logic                open,
   output logic                change_out,
   output logic                coin_reject,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit
);

   if ((PRICE - 1 + COIN_HI_VAL) >= (1 << CREDIT_W) ||
       (PRICE % COIN_LO_VAL) != 0 || (COIN_HI_VAL % COIN_LO_VAL) != 0 ||
       PRICE <= 0 || COIN_LO_VAL <= 0) begin : g_param_check
      $error("vending_machine_credit: illegal PRICE/COIN/CREDIT_W combination");
   end

   localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]   LO_X    = (CREDIT_W+1)'(COIN_LO_VAL);
   localparam logic [CREDIT_W:0]   HI_X    = (CREDIT_W+1)'(COIN_HI_VAL);
   localparam logic [CREDIT_W-1:0] LO_N    = CREDIT_W'(COIN_LO_VAL);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      VEND,
      CHANGE
   } state_t;

   state_t              state, state_next;
   logic [CREDIT_W-1:0] credit_next;
   logic                reject_next;
   logic [CREDIT_W:0]   sum;
   logic                cancel_req;

`ifdef VM_CANCEL_EN
   assign cancel_req = cancel;
`else
   logic unused_cancel;
   assign unused_cancel = cancel;
   assign cancel_req    = 1'b0;
`endif

   always_comb begin
      state_next  = state;
      credit_next = credit;
      reject_next = 1'b0;
      sum         = '0;
      case (state)
         IDLE, COLLECT: begin
            // Cancel only matters once credit exists; it also refuses any coin in that cycle.
            if (state == COLLECT && cancel_req) begin
               state_next  = CHANGE;
               reject_next = coin_lo | coin_hi;
            end else if (coin_lo || coin_hi) begin
               sum         = {1'b0, credit} + (coin_hi ? HI_X : LO_X);
               reject_next = coin_hi & coin_lo;
               if (sum >= PRICE_X) begin
                  credit_next = CREDIT_W'(sum - PRICE_X);
                  state_next  = VEND;
               end else begin
                  credit_next = CREDIT_W'(sum);
                  state_next  = COLLECT;
               end
            end
         end
         VEND: begin
            reject_next = coin_lo | coin_hi;
            state_next  = (credit != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_next = coin_lo | coin_hi;
            credit_next = credit - LO_N;
            if (credit == LO_N) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next  = IDLE;
            credit_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         coin_reject <= 1'b0;
      end else begin
         state       <= state_next;
         credit      <= credit_next;
         coin_reject <= reject_next;
      end
   end

   assign open       = (state == VEND);
   assign change_out = (state == CHANGE);
   assign busy       = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vending_machine_credit.sv
// Self-checking bench for vending_machine_credit: credit/refund model plus directed scenarios.
// Cancel-dependent expectations follow VM_CANCEL_EN.
module tb_vending_machine_credit;

   localparam int PRICE = 15;
   localparam int LO    = 5;
   localparam int HI    = 10;
   localparam int CW    = 6;
`ifdef VM_CANCEL_EN
   localparam bit CANCEL_EN = 1'b1;
`else
   localparam bit CANCEL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          coin_lo = 1'b0, coin_hi = 1'b0, cancel = 1'b0;
   logic          open, change_out, coin_reject, busy;
   logic [CW-1:0] credit;

   int tests = 0;
   int fails = 0;
   int pulses = 0, busy_cycles = 0, opens = 0;

   vending_machine_credit #(
      .PRICE(PRICE), .COIN_LO_VAL(LO), .COIN_HI_VAL(HI), .CREDIT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .coin_lo(coin_lo), .coin_hi(coin_hi), .cancel(cancel),
      .open(open), .change_out(change_out), .coin_reject(coin_reject), .busy(busy),
      .credit(credit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: credit held as a number; a vend is a one-cycle flag, refunding drains credit by LO per cycle.
   int m_credit = 0;
   bit m_open = 0, m_refund = 0, m_rej = 0, m_valid = 0;

   always @(posedge clk) begin
      bit any;
      int take;
      any   = coin_lo || coin_hi;
      m_rej = 0;
      if (reset) begin
         m_credit = 0; m_open = 0; m_refund = 0; m_valid = 1;
      end else if (m_valid) begin
         if (m_open) begin
            m_rej    = any;
            m_open   = 0;
            m_refund = (m_credit > 0);
         end else if (m_refund) begin
            m_rej    = any;
            m_credit = m_credit - LO;
            if (m_credit == 0) m_refund = 0;
         end else if (CANCEL_EN && cancel && m_credit > 0) begin
            m_rej    = any;
            m_refund = 1;
         end else begin
            take     = coin_hi ? HI : (coin_lo ? LO : 0);
            m_rej    = coin_hi && coin_lo;
            m_credit = m_credit + take;
            if (m_credit >= PRICE) begin
               m_credit = m_credit - PRICE;
               m_open   = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("open", open, m_open);
         check("change_out", change_out, m_refund);
         check("busy", busy, m_open || m_refund);
         check("coin_reject", coin_reject, m_rej);
         check("credit", credit, m_credit);
      end
      if (change_out) pulses++;
      if (busy) busy_cycles++;
      if (open) opens++;
   end

   task automatic step(input bit lo, input bit hi, input bit can, input bit rst);
      coin_lo = lo; coin_hi = hi; cancel = can; reset = rst;
      @(posedge clk);
      #1;
      coin_lo = 0; coin_hi = 0; cancel = 0; reset = 0;
   endtask

   task automatic clear_counts();
      pulses = 0; busy_cycles = 0; opens = 0;
   endtask

   initial begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check("rst_credit", credit, 0);
      check("rst_open", open, 0);
      check("rst_busy", busy, 0);
      check("rst_change", change_out, 0);

      // 1: three low coins, exact price
      clear_counts();
      step(1, 0, 0, 0); check("t1_credit5", credit, 5);
      step(1, 0, 0, 0); check("t1_credit10", credit, 10);
      step(1, 0, 0, 0); check("t1_open", open, 1); check("t1_credit0", credit, 0);
      step(0, 0, 0, 0); check("t1_open_done", open, 0); check("t1_busy_done", busy, 0);
      step(0, 0, 0, 0);
      check("t1_pulses", pulses, 0); check("t1_opens", opens, 1);

      // 2: two high coins, one change pulse
      clear_counts();
      step(0, 1, 0, 0); check("t2_credit10", credit, 10);
      step(0, 1, 0, 0); check("t2_open", open, 1); check("t2_credit5", credit, 5);
      step(0, 0, 0, 0); check("t2_change", change_out, 1); check("t2_open_off", open, 0);
      step(0, 0, 0, 0); check("t2_credit0", credit, 0); check("t2_idle", busy, 0);
      step(0, 0, 0, 0);
      check("t2_pulses", pulses, 1); check("t2_busy_cycles", busy_cycles, 2);

      // 3: both coins at once from IDLE
      step(1, 1, 0, 0); check("t3_credit10", credit, 10); check("t3_reject", coin_reject, 1);
      step(0, 0, 0, 0); check("t3_reject_off", coin_reject, 0); check("t3_credit_hold", credit, 10);

      // 4: coins refused during VEND and CHANGE
      clear_counts();
      step(0, 1, 0, 0); check("t4_open", open, 1); check("t4_credit5", credit, 5);
      step(0, 1, 0, 0); check("t4_rej_vend", coin_reject, 1); check("t4_chg", change_out, 1);
      check("t4_credit_kept", credit, 5);
      step(0, 1, 0, 0); check("t4_rej_chg", coin_reject, 1); check("t4_credit0", credit, 0);
      step(0, 0, 0, 0); check("t4_credit_after", credit, 0);
      step(0, 0, 0, 0);
      check("t4_pulses", pulses, 1); check("t4_opens", opens, 1);

      // 5: cancel with credit 10
      clear_counts();
      step(1, 0, 0, 0); step(1, 0, 0, 0); check("t5_credit10", credit, 10);
      step(0, 0, 1, 0);
`ifdef VM_CANCEL_EN
      check("t5_refund_start", change_out, 1);
      step(0, 0, 0, 0); check("t5_credit5", credit, 5);
      step(0, 0, 0, 0); check("t5_credit0", credit, 0);
      step(0, 0, 0, 0);
      check("t5_pulses", pulses, 2); check("t5_opens", opens, 0);
      // cancel together with a coin: coin refused, refund of existing credit
      step(1, 0, 0, 0); check("t5b_credit5", credit, 5);
      step(0, 1, 1, 0); check("t5b_reject", coin_reject, 1); check("t5b_credit5_kept", credit, 5);
      step(0, 0, 0, 0); check("t5b_credit0", credit, 0);
      // cancel from IDLE is ignored
      step(0, 0, 1, 0); check("t5c_idle", busy, 0);
`else
      check("t5_ignored_credit", credit, 10); check("t5_ignored_busy", busy, 0);
      step(0, 0, 0, 0); check("t5_hold", credit, 10);
      step(1, 0, 0, 0); check("t5_vend", open, 1); check("t5_vend_credit", credit, 0);
      step(0, 0, 0, 0);
      check("t5_pulses", pulses, 0); check("t5_opens", opens, 1);
`endif

      // 6: reset during CHANGE
      step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
      check("t6_in_change", change_out, 1);
      step(0, 0, 0, 1);
      check("t6_credit0", credit, 0); check("t6_change0", change_out, 0); check("t6_busy0", busy, 0);
      step(1, 0, 0, 0); check("t6_coin_after", credit, 5);

      // Mixed burst checked only against the model
      for (int i = 0; i < 80; i++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
      end
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
